tdm_slot_scheduler: RTL and testbench

// - Time-division scheduler that shares one DATA_W output lane between NUM_STREAMS input streams.
// - Each stream owns a programmable slot length in clk cycles. Disabled streams are skipped.
// - Slot lengths and the enable mask are shadowed and take effect only at frame boundaries.
// - Sits between the stream sources and the serialiser/symbol stage. Supersedes fixed-order muxing.

---
 rtl/tdm_slot_scheduler_if.sv | 33 +++
 rtl/tdm_slot_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_tdm_slot_scheduler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_slot_scheduler_if.sv
// Signal bundle for tdm_slot_scheduler: control pulses, slot configuration,
// per-stream input words and the scheduled output lane.
interface tdm_slot_scheduler_if #(
  parameter int NUM_STREAMS = 3,
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 32
);
  localparam int IDX_W = $clog2(NUM_STREAMS);

  logic                          start;
  logic                          stop;
  logic                          cfg_we;
  logic [IDX_W-1:0]              cfg_idx;
  logic [CNT_W-1:0]              cfg_len;
  logic [NUM_STREAMS-1:0]        cfg_mask;
  logic [NUM_STREAMS*DATA_W-1:0] ds_data;
  logic [DATA_W-1:0]             out_data;
  logic                          out_valid;
  logic [IDX_W-1:0]              out_sel;
  logic                          frame_start;
  logic                          busy;
  logic                          cfg_err;

  modport master (
    output start, stop, cfg_we, cfg_idx, cfg_len, cfg_mask, ds_data,
    input  out_data, out_valid, out_sel, frame_start, busy, cfg_err
  );

  modport slave (
    input  start, stop, cfg_we, cfg_idx, cfg_len, cfg_mask, ds_data,
    output out_data, out_valid, out_sel, frame_start, busy, cfg_err
  );
endinterface

// File: rtl/tdm_slot_scheduler.sv
// TDM scheduler sharing one output lane between NUM_STREAMS streams with shadowed
// slot lengths and enable mask. Define TDM_GUARD_EN to insert idle guard cycles between slots.
module tdm_slot_scheduler #(
  parameter int NUM_STREAMS  = 3,
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 32,
  parameter int GUARD_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  tdm_slot_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_STREAMS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SLOT = 2'd2;
`ifdef TDM_GUARD_EN
  localparam logic [1:0] ST_GUARD = 2'd3;
  localparam bit         GUARD_ON = (GUARD_CYCLES != 0);
`else
  // GUARD_CYCLES has no effect when guard insertion is compiled out.
  if (GUARD_CYCLES < 0) begin : g_guard_unused
  end
`endif

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_sh_q [NUM_STREAMS];
  logic [CNT_W-1:0]       len_sh_d [NUM_STREAMS];
  logic [CNT_W-1:0]       len_act_q [NUM_STREAMS];
  logic [CNT_W-1:0]       len_act_d [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] mask_q, mask_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   first_q, first_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [IDX_W-1:0]       out_sel_q, out_sel_d;
  logic                   frame_start_q, frame_start_d;
  logic                   cfg_err_q, cfg_err_d;
`ifdef TDM_GUARD_EN
  logic [31:0]            gcnt_q, gcnt_d;
`endif

  logic [DATA_W-1:0] words [NUM_STREAMS];
  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  next_idx;
  logic              next_ok;
  logic              first_ok;

  always_comb begin
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      words[i] = bus.ds_data[i*DATA_W +: DATA_W];
    end
  end

  // Lowest enabled stream in the incoming mask, and lowest enabled stream above sel_q.
  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    next_idx  = '0;
    next_ok   = 1'b0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      if (bus.cfg_mask[i] && !first_ok) begin
        first_ok  = 1'b1;
        first_idx = IDX_W'(i);
      end
      if (mask_q[i] && (i > 32'(sel_q)) && !next_ok) begin
        next_ok  = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    len_sh_d      = len_sh_q;
    len_act_d     = len_act_q;
    mask_d        = mask_q;
    stop_pend_d   = stop_pend_q;
    first_d       = first_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    out_sel_d     = out_sel_q;
    frame_start_d = 1'b0;
    cfg_err_d     = cfg_err_q;
`ifdef TDM_GUARD_EN
    gcnt_d        = gcnt_q;
`endif

    if (bus.cfg_we) begin
      if (32'(bus.cfg_idx) < 32'(NUM_STREAMS)) begin
        len_sh_d[bus.cfg_idx] = bus.cfg_len;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // Frame-end and empty-mask exits below clear this again, so a stop that
    // lands on the last cycle of a frame is consumed by that frame.
    if (state_q != ST_IDLE && bus.stop) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_LOAD;
          stop_pend_d = bus.stop;
        end
      end
      ST_LOAD: begin
        for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
          len_act_d[i] = (len_sh_q[i] == '0) ? CNT_W'(1) : len_sh_q[i];
        end
        mask_d = bus.cfg_mask;
        if (!first_ok) begin
          cfg_err_d   = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          sel_d   = first_idx;
          cnt_d   = CNT_W'(1);
          first_d = 1'b1;
          state_d = ST_SLOT;
        end
      end
      ST_SLOT: begin
        out_data_d    = words[sel_q];
        out_sel_d     = sel_q;
        out_valid_d   = 1'b1;
        frame_start_d = first_q;
        first_d       = 1'b0;
        if (cnt_q == len_act_q[sel_q]) begin
          if (next_ok) begin
            sel_d = next_idx;
            cnt_d = CNT_W'(1);
`ifdef TDM_GUARD_EN
            if (GUARD_ON) begin
              state_d = ST_GUARD;
              gcnt_d  = 32'd1;
            end
`endif
          end else if (stop_pend_q || bus.stop) begin
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef TDM_GUARD_EN
      ST_GUARD: begin
        out_data_d = '0;
        if (gcnt_q == 32'(GUARD_CYCLES)) begin
          state_d = ST_SLOT;
        end else begin
          gcnt_d = gcnt_q + 32'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        len_sh_q[i]  <= CNT_W'(1);
        len_act_q[i] <= CNT_W'(1);
      end
      mask_q        <= '1;
      stop_pend_q   <= 1'b0;
      first_q       <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sel_q     <= '0;
      frame_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
`ifdef TDM_GUARD_EN
      gcnt_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      len_sh_q      <= len_sh_d;
      len_act_q     <= len_act_d;
      mask_q        <= mask_d;
      stop_pend_q   <= stop_pend_d;
      first_q       <= first_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_sel_q     <= out_sel_d;
      frame_start_q <= frame_start_d;
      cfg_err_q     <= cfg_err_d;
`ifdef TDM_GUARD_EN
      gcnt_q        <= gcnt_d;
`endif
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sel     = out_sel_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Scoreboard bench for tdm_slot_scheduler: a frame-list reference model queues the
// expected per-cycle status and scheduled words; a negedge monitor pops and compares.
module tb_tdm_slot_scheduler;
  localparam int NS = 3;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int IW = 2;
`ifdef TDM_GUARD_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_slot_scheduler_if #(.NUM_STREAMS(NS), .DATA_W(DW), .CNT_W(CW)) bus ();

  tdm_slot_scheduler #(
    .NUM_STREAMS (NS),
    .DATA_W      (DW),
    .CNT_W       (CW),
    .GUARD_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic valid;
    logic busy;
    logic err;
    logic zero;
  } cyc_t;

  typedef struct packed {
    logic [IW-1:0] sel;
    logic [DW-1:0] data;
    logic          fs;
  } word_t;

  cyc_t  cyc_q[$];
  word_t word_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  // Reference model: a frame is the flat list of stream indices it will emit
  // (-1 marks a guard gap); phase 0 idle, 1 load, 2 emitting.
  int unsigned sh_len[NS];
  int          phase;
  bit          spend;
  bit          m_err;
  bit          first;
  int          frame_q[$];

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) sh_len[s] = 1;
    phase = 0;
    spend = 1'b0;
    m_err = 1'b0;
    first = 1'b0;
    frame_q.delete();
  endfunction

  function automatic void model_step(input bit r, input bit st, input bit sp, input bit we,
                                     input int idx, input int unsigned len,
                                     input logic [NS-1:0] msk, input logic [NS*DW-1:0] d);
    bit valid;
    bit busy_now;
    int e;
    if (r) begin
      model_reset();
      cyc_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
      return;
    end
    valid    = 1'b0;
    busy_now = (phase != 0);
    case (phase)
      0: if (st) begin
        phase = 1;
        spend = sp;
      end
      1: begin
        frame_q.delete();
        for (int s = 0; s < NS; s++) begin
          if (msk[s]) begin
            if (frame_q.size() > 0) repeat (GAP) frame_q.push_back(-1);
            repeat ((sh_len[s] == 0) ? 1 : sh_len[s]) frame_q.push_back(s);
          end
        end
        if (frame_q.size() == 0) begin
          m_err = 1'b1;
          phase = 0;
          spend = 1'b0;
        end else begin
          phase = 2;
          first = 1'b1;
        end
      end
      default: begin
        e = frame_q.pop_front();
        if (e >= 0) begin
          valid = 1'b1;
          word_q.push_back('{IW'(e), d[e*DW +: DW], first});
          first = 1'b0;
        end
        if (frame_q.size() == 0) begin
          if (spend || sp) begin
            phase = 0;
            spend = 1'b0;
          end else begin
            phase = 1;
          end
        end
      end
    endcase
    if (busy_now && sp && phase != 0) spend = 1'b1;
    if (we) begin
      if (idx < NS) sh_len[idx] = len;
      else m_err = 1'b1;
    end
    cyc_q.push_back('{valid, (phase != 0), m_err, 1'b0});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc_t  c;
    word_t w;
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cyc_underflow actual=empty required=entry");
      end else begin
        c = cyc_q.pop_front();
        chk("out_valid", 64'(bus.out_valid), 64'(c.valid));
        chk("busy", 64'(bus.busy), 64'(c.busy));
        chk("cfg_err", 64'(bus.cfg_err), 64'(c.err));
        if (c.zero) begin
          chk("rst_out_data", 64'(bus.out_data), 64'd0);
          chk("rst_out_sel", 64'(bus.out_sel), 64'd0);
          chk("rst_frame_start", 64'(bus.frame_start), 64'd0);
        end else if (!bus.out_valid) begin
          chk("idle_frame_start", 64'(bus.frame_start), 64'd0);
        end
      end
      if (bus.out_valid) begin
        if (word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_underflow actual=sel%0d required=no_word", bus.out_sel);
        end else begin
          w = word_q.pop_front();
          chk("out_sel", 64'(bus.out_sel), 64'(w.sel));
          chk("out_data", 64'(bus.out_data), 64'(w.data));
          chk("frame_start", 64'(bus.frame_start), 64'(w.fs));
        end
      end
    end
  end

  task automatic step(input bit r, input bit st, input bit sp, input bit we, input int idx,
                      input int unsigned len, input logic [NS-1:0] msk);
    logic [63:0]      r64;
    logic [NS*DW-1:0] d;
    r64          = {$urandom(), $urandom()};
    d            = r64[NS*DW-1:0];
    rst          = r;
    bus.start    = st;
    bus.stop     = sp;
    bus.cfg_we   = we;
    bus.cfg_idx  = IW'(idx);
    bus.cfg_len  = len;
    bus.cfg_mask = msk;
    bus.ds_data  = d;
    model_step(r, st, sp, we, idx, len, msk, d);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n, input logic [NS-1:0] msk);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, msk);
  endtask

  task automatic cfgw(input int idx, input int unsigned len, input logic [NS-1:0] msk);
    step(1'b0, 1'b0, 1'b0, 1'b1, idx, len, msk);
  endtask

  initial begin
    logic [NS-1:0] rm;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_len  = '0;
    bus.cfg_mask = '1;
    bus.ds_data  = '0;
    model_reset();
    @(posedge clk);
    #2;
    cyc_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b111);

    // lens {2,3,1}, all streams, two full frames then stop
    cfgw(0, 2, 3'b111); cfgw(1, 3, 3'b111); cfgw(2, 1, 3'b111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b111);
    run(14, 3'b111);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b111);
    run(10, 3'b111);

    // mask 101
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b101);
    run(8, 3'b101);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b101);
    run(8, 3'b101);

    // zero length on stream 1, then mid-frame rewrite of stream 0
    cfgw(1, 0, 3'b111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b111);
    run(3, 3'b111);
    cfgw(0, 4, 3'b111);
    run(12, 3'b111);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b111);
    run(12, 3'b111);

    // stop in the 2nd cycle of a frame, then start+stop together
    cfgw(0, 2, 3'b111); cfgw(1, 3, 3'b111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b111);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b111);
    run(10, 3'b111);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'b111);
    run(10, 3'b111);

    // reset while stream 1 is on the lane
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b111);
    run(4, 3'b111);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b111);
    run(3, 3'b111);

    // out-of-range cfg_idx: error, shadows stay at reset length 1
    cfgw(3, 7, 3'b111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b111);
    run(6, 3'b111);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b111);
    run(6, 3'b111);

    // empty mask
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b000);
    run(4, 3'b000);

    // randomized traffic
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b111);
    rm = 3'b111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rm = ($urandom_range(0, 39) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      step(1'b0, ($urandom_range(0, 11) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0) ? 3 : int'($urandom_range(0, 2)),
           $urandom_range(0, 4), rm);
      if ($urandom_range(0, 299) == 0) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, rm);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, rm);
    run(40, rm);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("words_left", 64'(word_q.size()), 64'd0);
    chk("cycles_left", 64'(cyc_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
